// File: rtl/aes_dec_seq_if.sv
// ============================================================================
// Module   : aes_dec_seq_if
// Purpose  : Bus bundle for the sequential AES-128 decryptor: host handshake
//            plus the links to the external key-expansion and inverse-round units.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface aes_dec_seq_if;
  logic         start;
  logic         key_reuse;
  logic [127:0] key_in;
  logic [127:0] ct_in;
  logic         busy;
  logic         done;
  logic [127:0] pt_out;
  logic [3:0]   ke_round_o;
  logic [127:0] ke_key_o;
  logic [127:0] ke_key_i;
  logic [127:0] rnd_state_o;
  logic [127:0] rnd_key_o;
  logic         rnd_last_o;
  logic [127:0] rnd_state_i;

  modport slave (
    input  start, key_reuse, key_in, ct_in, ke_key_i, rnd_state_i,
    output busy, done, pt_out, ke_round_o, ke_key_o, rnd_state_o, rnd_key_o, rnd_last_o
  );

  modport master (
    output start, key_reuse, key_in, ct_in, ke_key_i, rnd_state_i,
    input  busy, done, pt_out, ke_round_o, ke_key_o, rnd_state_o, rnd_key_o, rnd_last_o
  );
endinterface

`default_nettype wire

// File: rtl/aes_dec_seq.sv
// ============================================================================
// Module   : aes_dec_seq
// Purpose  : Iterative AES-128 decryption sequencer with a stored, reusable
//            key schedule; the round datapaths live outside this block.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_dec_seq (
  input  logic          clk,
  input  logic          rst,
  aes_dec_seq_if.slave  bus
);

  localparam logic [3:0] LAST_RK     = 4'd10;
  localparam logic [3:0] FIRST_ROUND = 4'd9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    INIT  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic [127:0] pt_q, pt_d;
  logic         sched_valid_q, sched_valid_d;
  logic [127:0] slot_q [0:10];

  logic         slot_we;
  logic [3:0]   slot_waddr;
  logic [127:0] slot_wdata;
  logic         reuse_hit;

  assign reuse_hit  = bus.key_reuse && sched_valid_q && (bus.key_in == slot_q[0]);
  assign bus.pt_out = pt_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    data_d          = data_q;
    pt_d            = pt_q;
    sched_valid_d   = sched_valid_q;
    slot_we         = 1'b0;
    slot_waddr      = 4'd0;
    slot_wdata      = '0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.ke_round_o  = 4'd0;
    bus.ke_key_o    = '0;
    bus.rnd_state_o = '0;
    bus.rnd_key_o   = '0;
    bus.rnd_last_o  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        bus.done = (state_q == DONE);
        if (bus.start) begin
          slot_we    = 1'b1;
          slot_waddr = 4'd0;
          slot_wdata = bus.key_in;
          data_d     = bus.ct_in;
          if (reuse_hit) begin
            state_d = INIT;
          end else begin
            // Slot 0 is being overwritten, so the old schedule is no longer coherent
            state_d       = KEXP;
            cnt_d         = 4'd1;
            sched_valid_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end

      KEXP: begin
        bus.busy       = 1'b1;
        bus.ke_round_o = cnt_q;
        bus.ke_key_o   = slot_q[cnt_q - 4'd1];
        slot_we        = 1'b1;
        slot_waddr     = cnt_q;
        slot_wdata     = bus.ke_key_i;
        if (cnt_q == LAST_RK) begin
          sched_valid_d = 1'b1;
          state_d       = INIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      INIT: begin
        bus.busy = 1'b1;
        data_d   = data_q ^ slot_q[10];
        cnt_d    = FIRST_ROUND;
        state_d  = ROUND;
      end

      ROUND: begin
        bus.busy        = 1'b1;
        bus.rnd_state_o = data_q;
        bus.rnd_key_o   = slot_q[cnt_q];
        bus.rnd_last_o  = (cnt_q == 4'd0);
        data_d          = bus.rnd_state_i;
        if (cnt_q == 4'd0) begin
          pt_d    = bus.rnd_state_i;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      data_q        <= '0;
      pt_q          <= '0;
      sched_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      pt_q          <= pt_d;
      sched_valid_q <= sched_valid_d;
    end
  end

  // Schedule storage is left uninitialised; sched_valid_q guards its use
  always_ff @(posedge clk) begin
    if (slot_we && !rst) begin
      slot_q[slot_waddr] <= slot_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_dec_seq.sv
// ============================================================================
// Module   : tb_aes_dec_seq
// Purpose  : Directed FIPS-197 vectors for aes_dec_seq, with behavioural models
//            of the external key-expansion and inverse-round units.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_dec_seq;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  aes_dec_seq_if bus ();

  aes_dec_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- GF(2^8) helpers for the external-unit models ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = ginv(b);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] ke_next(input logic [3:0] r, input logic [127:0] k);
    logic [7:0]  rc;
    logic [31:0] t, w0, w1, w2, w3;
    rc = 8'h01;
    for (int j = 1; j < int'(r); j++) rc = xt(rc);
    t  = {k[23:0], k[31:24]};
    t  = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r + 4*c] = isbox(s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]) ^ k[127 - 8*(r + 4*c) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) b[r + 4*c] = a[r + 4*c];
      end else begin
        b[4*c]   = gmul(a[4*c], 8'd14) ^ gmul(a[4*c+1], 8'd11) ^ gmul(a[4*c+2], 8'd13) ^ gmul(a[4*c+3], 8'd9);
        b[4*c+1] = gmul(a[4*c], 8'd9)  ^ gmul(a[4*c+1], 8'd14) ^ gmul(a[4*c+2], 8'd11) ^ gmul(a[4*c+3], 8'd13);
        b[4*c+2] = gmul(a[4*c], 8'd13) ^ gmul(a[4*c+1], 8'd9)  ^ gmul(a[4*c+2], 8'd14) ^ gmul(a[4*c+3], 8'd11);
        b[4*c+3] = gmul(a[4*c], 8'd11) ^ gmul(a[4*c+1], 8'd13) ^ gmul(a[4*c+2], 8'd9)  ^ gmul(a[4*c+3], 8'd14);
      end
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
    return o;
  endfunction

  assign bus.ke_key_i    = ke_next(bus.ke_round_o, bus.ke_key_o);
  assign bus.rnd_state_i = inv_round(bus.rnd_state_o, bus.rnd_key_o, bus.rnd_last_o);

  // ---------------- checking and stimulus tasks ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [127:0] key, input logic [127:0] ct, input logic reuse);
    bus.key_in    = key;
    bus.ct_in     = ct;
    bus.key_reuse = reuse;
    bus.start     = 1'b1;
  endtask

  // Steps from the start-sampling edge until done; g1/g2 pulse a rogue start mid-run
  task automatic wait_done(input string tag, input int exp_lat, input logic [127:0] exp_pt,
                           input int exp_kexp, input logic [127:0] hold,
                           input int g1, input int g2);
    int   n;
    int   kexp;
    int   bad_busy;
    int   bad_hold;
    logic seen;
    n = 0; kexp = 0; bad_busy = 0; bad_hold = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) begin
        seen = 1'b1;
        if (bus.busy) bad_busy++;
      end else begin
        if (!bus.busy) bad_busy++;
        if (bus.pt_out !== hold) bad_hold++;
      end
      if (bus.ke_round_o != 4'd0) kexp++;
      if (n == g1 || n == g2) begin
        bus.start  = 1'b1;
        bus.key_in = K2;
        bus.ct_in  = C2;
      end else begin
        bus.start = 1'b0;
      end
    end
    check({tag, ".latency"}, 128'(n), 128'(exp_lat));
    check({tag, ".pt_out"}, bus.pt_out, exp_pt);
    check({tag, ".kexp_cycles"}, 128'(kexp), 128'(exp_kexp));
    check({tag, ".busy_profile"}, 128'(bad_busy), 128'(0));
    check({tag, ".pt_hold"}, 128'(bad_hold), 128'(0));
  endtask

  task automatic check_idle(input string tag, input logic [127:0] hold);
    @(posedge clk);
    #1;
    check({tag, ".idle_done"}, 128'(bus.done), 128'(0));
    check({tag, ".idle_busy"}, 128'(bus.busy), 128'(0));
    check({tag, ".idle_pt"}, bus.pt_out, hold);
    check({tag, ".idle_ke"}, {bus.ke_key_o[123:0], bus.ke_round_o}, 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.key_reuse = 1'b0;
    bus.key_in    = '0;
    bus.ct_in     = '0;
    repeat (2) @(posedge clk);
    #1;
    // start together with rst must be ignored
    launch(K1, C1, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("reset.busy", 128'(bus.busy), 128'(0));
    check("reset.done", 128'(bus.done), 128'(0));
    check("reset.pt_out", bus.pt_out, 128'(0));
    check("reset.ke_round", 128'(bus.ke_round_o), 128'(0));
    check("reset.rnd_last", 128'(bus.rnd_last_o), 128'(0));
    check("reset.rnd_state", bus.rnd_state_o, 128'(0));

    launch(K1, C1, 1'b0);
    wait_done("fips", 22, P1, 10, 128'(0), -1, -1);
    check_idle("fips", P1);

    launch(K1, C1, 1'b1);
    wait_done("reuse", 12, P1, 0, P1, -1, -1);
    check_idle("reuse", P1);

    launch(K2, C2, 1'b1);
    wait_done("keydiff", 22, P2, 10, P1, -1, -1);
    check_idle("keydiff", P2);

    // Reset in ROUND (cycle 15), then reuse request must fall back to expansion
    launch(K1, C1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    check("midrst.in_round", 128'(bus.rnd_state_o != '0 || bus.rnd_key_o != '0), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst.busy", 128'(bus.busy), 128'(0));
    check("midrst.done", 128'(bus.done), 128'(0));
    check("midrst.pt_out", bus.pt_out, 128'(0));
    launch(K2, C2, 1'b1);
    wait_done("postrst", 22, P2, 10, 128'(0), -1, -1);
    check_idle("postrst", P2);

    launch(K1, C1, 1'b0);
    wait_done("glitch", 22, P1, 10, P2, 3, 10);
    check_idle("glitch", P1);

    // Back-to-back: each new start lands in the DONE cycle of the previous run
    launch(K1, C1, 1'b1);
    wait_done("b2b1", 12, P1, 0, P1, -1, -1);
    launch(K2, C2, 1'b1);
    wait_done("b2b2", 22, P2, 10, P1, -1, -1);
    launch(K2, C2, 1'b1);
    wait_done("b2b3", 12, P2, 0, P2, -1, -1);
    check_idle("b2b", P2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_dec_seq.md
AES_DEC_SEQ -- requirements
Module: aes_dec_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 start  input  1  request to decrypt ct_in; sampled only while busy=0.
REQ-004 key_reuse  input  1  sampled with start; 1 requests reuse of the stored key schedule.
REQ-005 key_in  input  128  cipher key (round key 0), sampled with accepted start.
REQ-006 ct_in  input  128  ciphertext, sampled with accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start until the cycle before done.
REQ-008 done  output  1  one-cycle pulse; pt_out valid in the same cycle.
REQ-009 pt_out  output  128  plaintext register; holds its value until the next done or rst.
REQ-010 ke_round_o  output  4  round-constant index driven to the external combinational key-expansion unit.
REQ-011 ke_key_o  output  128  previous round key driven to the key-expansion unit.
REQ-012 ke_key_i  input  128  next round key returned combinationally by the key-expansion unit.
REQ-013 rnd_state_o  output  128  state driven to the external combinational inverse-round unit.
REQ-014 rnd_key_o  output  128  round key driven to the inverse-round unit.
REQ-015 rnd_last_o  output  1  1 = final round; the inverse-round unit skips InvMixColumns.
REQ-016 rnd_state_i  input  128  result of InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless rnd_last_o=1.

Function
REQ-017 FSM states: IDLE, KEXP, INIT, ROUND, DONE; busy=1 only in KEXP, INIT and ROUND.
REQ-018 Start acceptance: start=1 in IDLE or DONE.
- Latch key_in into schedule slot 0 and ct_in into the state register.
- Next state is INIT when key_reuse=1, sched_valid=1 and key_in equals stored slot 0; otherwise KEXP.
REQ-019 start while busy=1 is ignored: no latch, no queuing.
REQ-020 KEXP: 10 cycles, counter r=1..10.
- Drive ke_round_o=r and ke_key_o=slot[r-1].
- Write ke_key_i into slot[r] at end of cycle.
- After r=10, set sched_valid=1 and go to INIT.
REQ-021 INIT: one cycle; state <= state XOR slot[10]; go to ROUND with counter i=9.
REQ-022 ROUND: 10 cycles, i=9 down to 0.
- Drive rnd_state_o=state, rnd_key_o=slot[i], rnd_last_o=(i==0).
- state <= rnd_state_i.
- After i=0, go to DONE.
REQ-023 DONE: one cycle.
- done=1; pt_out holds the final state (loaded on the transition into DONE).
- Next state is IDLE unless a start is accepted.
REQ-024 Latency from the start-sampling edge to done high:
- 22 cycles with expansion (10 KEXP + 1 INIT + 10 ROUND + 1).
- 12 cycles on schedule reuse.
REQ-025 Outside their active states:
- ke_* outputs are 0.
- rnd_state_o and rnd_key_o are 0.
- rnd_last_o is 0.
REQ-026 Key schedule: 11x128 register storage, writable only in KEXP and on start (slot 0).
REQ-027 key_reuse=1 with sched_valid=0 or a key mismatch forces full expansion; no error is flagged.
REQ-028 Back-to-back operation: a start accepted in DONE makes the next cycle KEXP or INIT; there are no idle cycles between operations.

Reset
REQ-029 rst=1 at any time, including mid-operation, takes effect at the next edge:
- FSM to IDLE; busy=0, done=0.
- pt_out=0, all counters 0, sched_valid=0.
REQ-030 Schedule slot contents need not be cleared; sched_valid=0 makes them unusable.
REQ-031 start asserted together with rst is ignored.

Verification
REQ-032 FIPS-197 test: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, key_reuse=0.
- done exactly 22 cycles after start.
- pt_out=00112233445566778899aabbccddeeff.
REQ-033 Repeat REQ-032 immediately with key_reuse=1 and the same key -> done after 12 cycles, same pt_out, no KEXP cycles (ke_round_o stays 0).
REQ-034 key_reuse=1 with a different key (2b7e151628aed2a6abf7158809cf4f3c) and ct 3925841d02dc09fbdc118597196a0b32.
- Full 22-cycle run.
- pt_out=3243f6a8885a308d313198a2e0370734.
REQ-035 Assert rst during ROUND (cycle 15 of a run).
- busy=0, done=0, pt_out=0 next cycle.
- A following start with key_reuse=1 performs a 22-cycle run.
REQ-036 Pulse start on cycles 3 and 10 of an active run -> ignored; exactly one done; result unchanged.
REQ-037 Assert start in the DONE cycle with a new ct -> second done 22 (or 12 on reuse) cycles later; first pt_out held until then.
